// File: rtl/piano_pkg.sv
// piano_pkg: shared constants and types for the piano datapath.
//   NKEYS               - number of keys (shared with divider and mixer)
//   DEB_CYCLES_DEFAULT  - default debounce window in clk cycles (1 ms at 50 MHz)
//   key_state_e         - per-key debounce FSM state
//   popcount_keys()     - number of set bits in a key vector (0..NKEYS)
package piano_pkg;

  localparam int NKEYS = 8;
  localparam int unsigned DEB_CYCLES_DEFAULT = 50000;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } key_state_e;

  // 4-bit result covers 0..8 with no wrap.
  function automatic logic [3:0] popcount_keys(input logic [NKEYS-1:0] v);
    logic [3:0] sum;
    sum = 4'd0;
    for (int i = 0; i < NKEYS; i++) begin
      sum = sum + 4'(v[i]);
    end
    return sum;
  endfunction

endpackage

// File: rtl/key_debounce_cell.sv
// key_debounce_cell: one key's 2-flop synchronizer, debounce FSM and counter.
// Ports:
//   clk      - system clock, rising edge
//   rst      - synchronous active-high reset
//   t_i      - raw asynchronous key input, 1 = pressed
//   held_o   - debounced state, 1 in HELD and RELEASE_WAIT
//   rise_o   - high while the FSM will move PRESS_WAIT->HELD on the next edge
//   fall_o   - high while the FSM will move RELEASE_WAIT->IDLE on the next edge
//   state_o  - current FSM state (debug visibility)
// rise_o/fall_o are next-edge indications so the parent can register its
// chord, count and strobes on the very edge the key commits.
module key_debounce_cell
  import piano_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       t_i,
  output logic       held_o,
  output logic       rise_o,
  output logic       fall_o,
  output key_state_e state_o
);

  localparam int CNT_W = $clog2(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             s1_q, s2_q;
  key_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (s2_q) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!s2_q)                state_d = IDLE;
        else if (cnt_q == CNT_LAST) state_d = HELD;
        else                      cnt_d = cnt_q + CNT_W'(1);
      end
      HELD: begin
        if (!s2_q) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (s2_q)                   state_d = HELD;
        else if (cnt_q == CNT_LAST) state_d = IDLE;
        else                        cnt_d = cnt_q + CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      s1_q    <= t_i;
      s2_q    <= s1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign held_o  = (state_q == HELD) || (state_q == RELEASE_WAIT);
  assign rise_o  = (state_q == PRESS_WAIT) && (state_d == HELD);
  assign fall_o  = (state_q == RELEASE_WAIT) && (state_d == IDLE);
  assign state_o = state_q;

endmodule

// File: rtl/key_scanner.sv
// key_scanner: debounces NKEYS raw key inputs into a stable chord vector.
// Ports:
//   clk          - system clock, rising edge
//   rst          - synchronous active-high reset
//   t            - raw key inputs, bit i = key i, 1 = pressed
//   chord        - debounced key state, 1 = held
//   key_count    - number of held keys, 0..8
//   chord_valid  - strobe: high for one cycle, on the first cycle chord shows a
//                  new value; several keys committing together give one strobe.
//                  There is no back-pressure; consumers must take it that cycle.
//   note_on      - per-key press strobe    (only with KEY_SCANNER_EVENT_EN)
//   note_off     - per-key release strobe  (only with KEY_SCANNER_EVENT_EN)
// Optional feature macro: KEY_SCANNER_EVENT_EN.
module key_scanner
  import piano_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NKEYS-1:0] t,
  output logic [NKEYS-1:0] chord,
  output logic [3:0]       key_count,
  output logic             chord_valid
`ifdef KEY_SCANNER_EVENT_EN
  ,
  output logic [NKEYS-1:0] note_on,
  output logic [NKEYS-1:0] note_off
`endif
);

  logic [NKEYS-1:0] held, rise, fall;
  key_state_e       key_state [NKEYS];

  for (genvar i = 0; i < NKEYS; i++) begin : g_key
    key_debounce_cell #(.DEB_CYCLES(DEB_CYCLES)) u_cell (
      .clk    (clk),
      .rst    (rst),
      .t_i    (t[i]),
      .held_o (held[i]),
      .rise_o (rise[i]),
      .fall_o (fall[i]),
      .state_o(key_state[i])
    );

    held_matches_state: assert property (@(posedge clk) disable iff (rst)
      held[i] == ((key_state[i] == HELD) || (key_state[i] == RELEASE_WAIT)));
  end

  logic [NKEYS-1:0] chord_q, chord_d;
  logic [3:0]       key_count_q;
  logic             chord_valid_q;

  // Next-edge chord: keys about to commit flip, everything else follows held.
  always_comb begin
    chord_d = (held | rise) & ~fall;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      chord_q       <= '0;
      key_count_q   <= 4'd0;
      chord_valid_q <= 1'b0;
    end else begin
      chord_q       <= chord_d;
      key_count_q   <= popcount_keys(chord_d);
      chord_valid_q <= (chord_d != chord_q);
    end
  end

  assign chord       = chord_q;
  assign key_count   = key_count_q;
  assign chord_valid = chord_valid_q;

`ifdef KEY_SCANNER_EVENT_EN
  logic [NKEYS-1:0] note_on_q, note_off_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      note_on_q  <= '0;
      note_off_q <= '0;
    end else begin
      note_on_q  <= rise;
      note_off_q <= fall;
    end
  end

  assign note_on  = note_on_q;
  assign note_off = note_off_q;
`endif

endmodule

// File: tb/tb_key_scanner.sv
// tb_key_scanner: table-driven bench for key_scanner with DEB_CYCLES = 4.
// Each table record holds inputs for n cycles and the outputs expected after
// every one of those cycles. A chord_valid monitor pops expected chords from
// exp_q. Press/release latency from the first edge that sees t is 7 edges
// (2 synchronizer edges + IDLE->PRESS_WAIT + 4 counting edges).
module tb_key_scanner;

  logic       clk;
  logic       rst;
  logic [7:0] t;
  logic [7:0] chord;
  logic [3:0] key_count;
  logic       chord_valid;
`ifdef KEY_SCANNER_EVENT_EN
  logic [7:0] note_on;
  logic [7:0] note_off;
`endif

  key_scanner #(.DEB_CYCLES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .t          (t),
    .chord      (chord),
    .key_count  (key_count),
    .chord_valid(chord_valid)
`ifdef KEY_SCANNER_EVENT_EN
    ,
    .note_on    (note_on),
    .note_off   (note_off)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every chord_valid pulse must match the next queued chord.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (chord_valid) begin
        if (exp_q.size() == 0) chk("unexpected_valid", 32'(chord), 32'hFFFF_FFFF);
        else                   chk("valid_chord", 32'(chord), 32'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic       rst;
    logic [7:0] t;
    int         n;
    logic [7:0] chord;
    logic [3:0] cnt;
    logic       valid;
    logic [7:0] on;
    logic [7:0] off;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic [7:0] tv, input int n,
                              input logic [7:0] ch, input logic [3:0] cn,
                              input logic va, input logic [7:0] on, input logic [7:0] off);
    vec_t v;
    v.rst = r; v.t = tv; v.n = n; v.chord = ch; v.cnt = cn;
    v.valid = va; v.on = on; v.off = off;
    vecs.push_back(v);
  endfunction

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int lat;

  initial begin
    rst = 1'b1;
    t   = 8'h00;

    // Reset with all keys down, then full-chord press and release.
    add(1, 8'hFF, 3, 8'h00, 0, 0, 8'h00, 8'h00);
    add(0, 8'hFF, 6, 8'h00, 0, 0, 8'h00, 8'h00);
    add(0, 8'hFF, 1, 8'hFF, 8, 1, 8'hFF, 8'h00);
    add(0, 8'hFF, 3, 8'hFF, 8, 0, 8'h00, 8'h00);
    add(0, 8'h00, 6, 8'hFF, 8, 0, 8'h00, 8'h00);
    add(0, 8'h00, 1, 8'h00, 0, 1, 8'h00, 8'hFF);
    add(0, 8'h00, 2, 8'h00, 0, 0, 8'h00, 8'h00);
    // Single press / release of key 3.
    add(0, 8'h08, 6, 8'h00, 0, 0, 8'h00, 8'h00);
    add(0, 8'h08, 1, 8'h08, 1, 1, 8'h08, 8'h00);
    add(0, 8'h08, 2, 8'h08, 1, 0, 8'h00, 8'h00);
    add(0, 8'h00, 6, 8'h08, 1, 0, 8'h00, 8'h00);
    add(0, 8'h00, 1, 8'h00, 0, 1, 8'h00, 8'h08);
    add(0, 8'h00, 2, 8'h00, 0, 0, 8'h00, 8'h00);
    // Bounce on key 5: 3 high, 1 low, 3 high, low -> nothing.
    add(0, 8'h20, 3, 8'h00, 0, 0, 8'h00, 8'h00);
    add(0, 8'h00, 1, 8'h00, 0, 0, 8'h00, 8'h00);
    add(0, 8'h20, 3, 8'h00, 0, 0, 8'h00, 8'h00);
    add(0, 8'h00, 8, 8'h00, 0, 0, 8'h00, 8'h00);
    // Key 5 held long enough commits, then releases.
    add(0, 8'h20, 6, 8'h00, 0, 0, 8'h00, 8'h00);
    add(0, 8'h20, 1, 8'h20, 1, 1, 8'h20, 8'h00);
    add(0, 8'h00, 6, 8'h20, 1, 0, 8'h00, 8'h00);
    add(0, 8'h00, 1, 8'h00, 0, 1, 8'h00, 8'h20);
    // Chord 81, release key 0, re-press, 2-cycle dip during RELEASE_WAIT.
    add(0, 8'h81, 6, 8'h00, 0, 0, 8'h00, 8'h00);
    add(0, 8'h81, 1, 8'h81, 2, 1, 8'h81, 8'h00);
    add(0, 8'h80, 6, 8'h81, 2, 0, 8'h00, 8'h00);
    add(0, 8'h80, 1, 8'h80, 1, 1, 8'h00, 8'h01);
    add(0, 8'h80, 2, 8'h80, 1, 0, 8'h00, 8'h00);
    add(0, 8'h81, 6, 8'h80, 1, 0, 8'h00, 8'h00);
    add(0, 8'h81, 1, 8'h81, 2, 1, 8'h01, 8'h00);
    add(0, 8'h80, 2, 8'h81, 2, 0, 8'h00, 8'h00);
    add(0, 8'h81, 8, 8'h81, 2, 0, 8'h00, 8'h00);
    add(0, 8'h00, 6, 8'h81, 2, 0, 8'h00, 8'h00);
    add(0, 8'h00, 1, 8'h00, 0, 1, 8'h00, 8'h81);
    add(0, 8'h00, 1, 8'h00, 0, 0, 8'h00, 8'h00);
    // Simultaneous press of four keys, then release.
    add(0, 8'h0F, 6, 8'h00, 0, 0, 8'h00, 8'h00);
    add(0, 8'h0F, 1, 8'h0F, 4, 1, 8'h0F, 8'h00);
    add(0, 8'h00, 6, 8'h0F, 4, 0, 8'h00, 8'h00);
    add(0, 8'h00, 1, 8'h00, 0, 1, 8'h00, 8'h0F);
    add(0, 8'h00, 1, 8'h00, 0, 0, 8'h00, 8'h00);
    // Reset two cycles into PRESS_WAIT of key 1: full latency afterwards.
    add(0, 8'h02, 4, 8'h00, 0, 0, 8'h00, 8'h00);
    add(1, 8'h02, 2, 8'h00, 0, 0, 8'h00, 8'h00);
    add(0, 8'h02, 6, 8'h00, 0, 0, 8'h00, 8'h00);
    add(0, 8'h02, 1, 8'h02, 1, 1, 8'h02, 8'h00);
    add(0, 8'h02, 2, 8'h02, 1, 0, 8'h00, 8'h00);
    // Key 1 releases while key 2 presses: same count, one strobe.
    add(0, 8'h04, 6, 8'h02, 1, 0, 8'h00, 8'h00);
    add(0, 8'h04, 1, 8'h04, 1, 1, 8'h04, 8'h02);
    add(0, 8'h00, 6, 8'h04, 1, 0, 8'h00, 8'h00);
    add(0, 8'h00, 1, 8'h00, 0, 1, 8'h00, 8'h04);
    add(0, 8'h00, 2, 8'h00, 0, 0, 8'h00, 8'h00);

    foreach (vecs[k]) begin
      rst = vecs[k].rst;
      t   = vecs[k].t;
      if (vecs[k].valid) exp_q.push_back(vecs[k].chord);
      repeat (vecs[k].n) begin
        tick();
        chk($sformatf("chord[v%0d]", k), 32'(chord), 32'(vecs[k].chord));
        chk($sformatf("count[v%0d]", k), 32'(key_count), 32'(vecs[k].cnt));
        chk($sformatf("valid[v%0d]", k), 32'(chord_valid), 32'(vecs[k].valid));
`ifdef KEY_SCANNER_EVENT_EN
        chk($sformatf("note_on[v%0d]", k), 32'(note_on), 32'(vecs[k].on));
        chk($sformatf("note_off[v%0d]", k), 32'(note_off), 32'(vecs[k].off));
`endif
      end
    end

    // Hand-written: measure press latency of key 7 with a bounded wait.
    t = 8'h80;
    exp_q.push_back(8'h80);
    lat = 0;
    while (!chord[7] && lat < 20) begin
      tick();
      lat++;
    end
    chk("press_latency", 32'(lat), 32'd7);
    chk("latency_valid", 32'(chord_valid), 32'd1);
    chk("latency_count", 32'(key_count), 32'd1);
    tick();
    chk("strobe_one_cycle", 32'(chord_valid), 32'd0);
    chk("chord_stays", 32'(chord), 32'h80);

    tick();
    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
